// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM state encodings (ST_IDLE/ST_FETCH/ST_FLUSH/ST_HALT)
//   OPCODE_*      : a few RV32I major opcodes used by decode and the bench
//   INSTR_NOP     : canonical NOP (addi x0,x0,0), used as an idle fill value
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
    localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;

endpackage

// File: rtl/riscv_fetch_if.sv
// riscv_fetch_if
// Instruction-memory request/response bus between the fetch stage and imem.
//   fetch_imem_req    : request valid (fetch -> imem)
//   fetch_imem_addr   : request byte address, word aligned (fetch -> imem)
//   fetch_imem_gnt    : request accepted this cycle when req & gnt (imem -> fetch)
//   fetch_imem_rvalid : response valid, in request order (imem -> fetch)
//   fetch_imem_rdata  : response instruction word (imem -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
interface riscv_fetch_if;
    logic        fetch_imem_req;
    logic [31:0] fetch_imem_addr;
    logic        fetch_imem_gnt;
    logic        fetch_imem_rvalid;
    logic [31:0] fetch_imem_rdata;

    modport master (
        output fetch_imem_req, fetch_imem_addr,
        input  fetch_imem_gnt, fetch_imem_rvalid, fetch_imem_rdata
    );

    modport slave (
        input  fetch_imem_req, fetch_imem_addr,
        output fetch_imem_gnt, fetch_imem_rvalid, fetch_imem_rdata
    );
endinterface

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo
// Small synchronous FIFO with combinational head read.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_push, i_wdata   : write request and data (accepted when not full, or full with pop)
//   i_pop             : remove head entry (ignored when empty)
//   i_flush           : discard all entries; overrides push/pop in the same cycle
//   o_rdata           : head entry
//   o_full, o_empty   : occupancy flags
//   o_count           : number of stored entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module riscv_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_en;
    logic             pop_en;

    assign pop_en  = i_pop && (count_reg != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_en = i_push && ((count_reg != FULL_CNT) || pop_en);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk) begin
                if (push_en && !i_flush && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= i_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign o_rdata = mem_reg[rd_ptr_reg];
    assign o_full  = (count_reg == FULL_CNT);
    assign o_empty = (count_reg == '0);
    assign o_count = count_reg;
endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch
// Instruction fetch stage: holds the PC, issues word requests on the imem bus,
// buffers returned words and presents {pc, instr, opcode, funct3, funct7_5b} to
// decode with a valid/ready handshake. Redirects flush the buffer and drop the
// responses of requests that were still in flight.
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   imem (riscv_fetch_if)     : req/addr out, gnt/rvalid/rdata in
//   i_fetch_redirect(_pc)     : redirect pulse and target
//   o_fetch_valid/i_fetch_ready : decode handshake
//   o_fetch_pc/instr/opcode/funct3/funct7_5b : presented instruction and fields
//   o_fetch_misalign          : sticky misaligned-redirect flag
// Build option: FETCH_MISALIGN_CHK_EN -- when defined, a misaligned redirect
// target sets o_fetch_misalign and parks the stage in ST_HALT until reset;
// otherwise target[1:0] is ignored and o_fetch_misalign is tied low.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    riscv_fetch_if.master        imem,
    input  logic                 i_fetch_redirect,
    input  logic [31:0]          i_fetch_redirect_pc,
    output logic                 o_fetch_valid,
    input  logic                 i_fetch_ready,
    output logic [31:0]          o_fetch_pc,
    output logic [31:0]          o_fetch_instr,
    output logic [6:0]           o_fetch_opcode,
    output logic [2:0]           o_fetch_funct3,
    output logic                 o_fetch_funct7_5b,
    output logic                 o_fetch_misalign
);
    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    fetch_state_t  state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [CW-1:0] drop_reg, drop_next;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic          fifo_full, fifo_empty, fifo_flush, fifo_pop;
    logic [63:0]   fifo_head;
    logic [31:0]   req_pc_head;
    logic          aq_full, aq_empty;
    logic          req, grant, rvalid, rsp_keep, credit_ok, redirect_active;
    logic [31:0]   target_pc;
    logic          target_bad;

    assign rvalid          = imem.fetch_imem_rvalid;
    assign grant           = req && imem.fetch_imem_gnt;
    assign rsp_keep        = rvalid && (drop_reg == '0);
    assign credit_ok       = ({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT_MAX;
    assign redirect_active = i_fetch_redirect && ((state_reg == ST_FETCH) || (state_reg == ST_FLUSH));

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_reg;
    assign target_pc  = i_fetch_redirect_pc;
    assign target_bad = |i_fetch_redirect_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst)                             misalign_reg <= 1'b0;
        else if (redirect_active && target_bad) misalign_reg <= 1'b1;
    end
    assign o_fetch_misalign = misalign_reg;
`else
    assign target_pc        = i_fetch_redirect_pc & 32'hFFFF_FFFC;
    assign target_bad       = 1'b0;
    assign o_fetch_misalign = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;
        req        = 1'b0;
        fifo_flush = 1'b0;

        // Stale responses are discarded in any state while drop is pending.
        if (rvalid && (drop_reg != '0)) drop_next = drop_reg - 1'b1;

        case (state_reg)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: begin
                req = credit_ok && !i_fetch_redirect;
                if (req && imem.fetch_imem_gnt) pc_next = pc_reg + 32'd4;
            end
            ST_FLUSH: if (drop_next == '0) state_next = ST_FETCH;
            default:  ;
        endcase

        // Everything issued before the redirect (minus a response landing now)
        // must be thrown away when it returns.
        if (redirect_active) begin
            fifo_flush = 1'b1;
            pc_next    = target_pc;
            drop_next  = outstanding - {{(CW-1){1'b0}}, rvalid};
            if (target_bad)              state_next = ST_HALT;
            else if (drop_next != '0)    state_next = ST_FLUSH;
            else                         state_next = ST_FETCH;
        end
    end

    // Addresses of issued requests, popped in order as responses return.
    riscv_fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_req_pc_q (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (grant),
        .i_wdata (pc_reg),
        .i_pop   (rvalid),
        .i_flush (1'b0),
        .o_rdata (req_pc_head),
        .o_full  (aq_full),
        .o_empty (aq_empty),
        .o_count (outstanding)
    );

    assign fifo_pop = o_fetch_valid && i_fetch_ready;

    riscv_fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (rsp_keep),
        .i_wdata ({req_pc_head, imem.fetch_imem_rdata}),
        .i_pop   (fifo_pop),
        .i_flush (fifo_flush),
        .o_rdata (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign imem.fetch_imem_req  = req;
    assign imem.fetch_imem_addr = req ? pc_reg : 32'd0;

    // Fields are gated so nothing undefined leaves the stage while empty.
    assign o_fetch_valid     = !fifo_empty;
    assign o_fetch_pc        = o_fetch_valid ? fifo_head[63:32] : 32'd0;
    assign o_fetch_instr     = o_fetch_valid ? fifo_head[31:0]  : 32'd0;
    assign o_fetch_opcode    = o_fetch_instr[6:0];
    assign o_fetch_funct3    = o_fetch_instr[14:12];
    assign o_fetch_funct7_5b = o_fetch_instr[30];

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(rsp_keep && fifo_full && !fifo_pop && !redirect_active));
    a_no_spurious_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
        !(rvalid && aq_empty));
    a_no_excess_grant: assert property (@(posedge i_clk) disable iff (i_rst)
        !(grant && aq_full));
endmodule
